rs485_frame_tx: RTL and testbench

//  Parametrised RS-485 frame transmitter; next generation of the single-rate UART TX.
//  On a request, asserts the transceiver direction pins with guard delays and reads NBYTES from an external buffer via addr/data.

---
 rtl/rs485_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 26 ++
 rtl/rs485_frame_tx.sv | 119 +++++++++++
 tb/tb_rs485_frame_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// rs485_pkg: shared FSM state type, parity codes and character-length helper for the RS-485 frame transmitter.
package rs485_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIRON,
        SEND,
        DIROFF,
        WAITLOW
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit slots per character: start + 8 data + optional parity + stops + idle gap.
    function automatic int char_bits(int parity, int stop_bits, int gap_bits);
        return 10 + (parity != PAR_NONE ? 1 : 0) + stop_bits - 1 + gap_bits;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period divider; tick is high on the last clk of every bit period.
//  clk   in  system clock
//  reset in  synchronous reset, active-low
//  clr   in  hold the divider at the start of a bit period
//  tick  out last cycle of the current bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    logic [7:0] r_cnt;

    assign tick = r_cnt == 8'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (!reset || clr)
            r_cnt <= 8'd0;
        else
            r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
    end

endmodule

// File: rtl/rs485_frame_tx.sv
// rs485_frame_tx: RS-485 frame transmitter with guarded direction control, reading bytes from a sync frame buffer.
//  clk    in  system clock
//  reset  in  synchronous reset, active-low
//  RQ     in  transfer request level, asynchronous
//  data   in  frame buffer byte at addr, one cycle read latency
//  addr   out frame buffer byte index
//  tx     out UART serial data, LSB first, idle high
//  dirTX  out transceiver driver enable
//  dirRX  out transceiver receiver direction control
//  busy   out frame in progress (DIRON, SEND, DIROFF)
//  done   out one-cycle pulse on entry to WAITLOW
module rs485_frame_tx
    import rs485_pkg::*;
#(
    parameter int NBYTES       = 18,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 1,
    parameter int GUARD        = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RQ,
    input  logic [7:0] data,
    output logic [4:0] addr,
    output logic       tx,
    output logic       dirTX,
    output logic       dirRX,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] G1       = 8'(GUARD);
    localparam logic [7:0] G2       = 8'(2 * GUARD);
    localparam logic [7:0] G3       = 8'(3 * GUARD);
    localparam logic [3:0] LAST     = 4'(char_bits(PARITY, STOP_BITS, GAP_BITS) - 1);
    localparam logic [3:0] STOP0    = (PARITY != PAR_NONE) ? 4'd10 : 4'd9;
    localparam logic [4:0] ADDR_MAX = 5'(NBYTES - 1);

    state_t     r_state, w_next;
    logic [1:0] r_sync;
    logic [7:0] r_g, r_shift;
    logic [3:0] r_idx;
    logic [4:0] r_addr;
    logic       r_par, r_load, r_done;
    logic       w_rq_s, w_tick, w_byte_end, w_start;

    assign w_rq_s = r_sync[1];
    assign addr   = r_addr;
    assign done   = r_done;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .reset(reset),
        .clr  (r_state != SEND),
        .tick (w_tick)
    );

    always_ff @(posedge clk)
        r_sync <= {r_sync[0], RQ};

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_byte_end = r_state == SEND && w_tick && r_idx == LAST;
        unique case (r_state)
            IDLE:    if (w_rq_s) w_next = DIRON;
            DIRON:   if (r_g == G3 - 8'd1) w_next = SEND;
            // addr has already wrapped to 0 when the final byte ends
            SEND:    if (w_byte_end && r_addr == 5'd0) w_next = DIROFF;
            DIROFF:  if (r_g == G2 - 8'd1) w_next = WAITLOW;
            WAITLOW: if (!w_rq_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_start = w_next == SEND && (r_state != SEND || w_byte_end);
        busy    = r_state == DIRON || r_state == SEND || r_state == DIROFF;
        dirRX   = (r_state == DIRON && r_g >= G1) || r_state == SEND || r_state == DIROFF;
        dirTX   = (r_state == DIRON && r_g >= G2) || r_state == SEND || (r_state == DIROFF && r_g < G1);
        tx      = r_state != SEND ? 1'b1 :
                  r_idx == 4'd0 ? 1'b0 :
                  r_idx <= 4'd8 ? r_shift[0] :
                  (r_idx == 4'd9 && PARITY != PAR_NONE) ? r_par : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_g     <= 8'd0;
            r_idx   <= 4'd0;
            r_addr  <= 5'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // r_load marks the first cycle of each start bit
            r_load <= w_start;
            r_done <= r_state == DIROFF && w_next == WAITLOW;
            r_g    <= (r_state == IDLE || (r_state == SEND && w_next == DIROFF)) ? 8'd0 :
                      (r_state == DIRON || r_state == DIROFF) ? r_g + 8'd1 : r_g;
            if (r_load) begin
                r_shift <= data;
                r_par   <= PARITY == PAR_ODD ? ~^data : ^data;
            end else if (r_state == SEND && w_tick && r_idx >= 4'd1 && r_idx <= 4'd8)
                r_shift <= r_shift >> 1;
            if (r_state == SEND && w_tick)
                r_idx <= r_idx == LAST ? 4'd0 : r_idx + 4'd1;
            if (r_state == SEND && w_tick && r_idx == STOP0 - 4'd1)
                r_addr <= r_addr == ADDR_MAX ? 5'd0 : r_addr + 5'd1;
        end
    end

endmodule

// File: tb/tb_rs485_frame_tx.sv
// tb_rs485_frame_tx: directed edge-by-edge check of four transmitter configurations against a frame timing model.
module tb_rs485_frame_tx;

    typedef struct {
        int         cpb;
        int         par;
        int         stp;
        int         gap;
        int         nb;
        int         g;
        logic [7:0] base;
        bit         inc;
    } cfg_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rq     [4];
    logic [7:0] data_i [4];
    logic [4:0] addr_o [4];
    logic       tx_o   [4];
    logic       dtx    [4];
    logic       drx    [4];
    logic       busy   [4];
    logic       done   [4];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    function automatic cfg_t cfg_of(int id);
        case (id)
            0:       return '{1, 0, 1, 1, 18, 15, 8'hA0, 1'b1};
            1:       return '{4, 1, 1, 1, 2, 15, 8'h07, 1'b0};
            2:       return '{1, 2, 2, 0, 2, 15, 8'hFF, 1'b0};
            default: return '{1, 0, 1, 1, 1, 1, 8'h5C, 1'b0};
        endcase
    endfunction

    rs485_frame_tx #(.NBYTES(18), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1), .GAP_BITS(1), .GUARD(15)) dut0 (
        .clk(clk), .reset(reset), .RQ(rq[0]), .data(data_i[0]), .addr(addr_o[0]),
        .tx(tx_o[0]), .dirTX(dtx[0]), .dirRX(drx[0]), .busy(busy[0]), .done(done[0]));
    rs485_frame_tx #(.NBYTES(2), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .GAP_BITS(1), .GUARD(15)) dut1 (
        .clk(clk), .reset(reset), .RQ(rq[1]), .data(data_i[1]), .addr(addr_o[1]),
        .tx(tx_o[1]), .dirTX(dtx[1]), .dirRX(drx[1]), .busy(busy[1]), .done(done[1]));
    rs485_frame_tx #(.NBYTES(2), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2), .GAP_BITS(0), .GUARD(15)) dut2 (
        .clk(clk), .reset(reset), .RQ(rq[2]), .data(data_i[2]), .addr(addr_o[2]),
        .tx(tx_o[2]), .dirTX(dtx[2]), .dirRX(drx[2]), .busy(busy[2]), .done(done[2]));
    rs485_frame_tx #(.NBYTES(1), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1), .GAP_BITS(1), .GUARD(1)) dut3 (
        .clk(clk), .reset(reset), .RQ(rq[3]), .data(data_i[3]), .addr(addr_o[3]),
        .tx(tx_o[3]), .dirTX(dtx[3]), .dirRX(drx[3]), .busy(busy[3]), .done(done[3]));

    // Frame buffers: synchronous RAM with one cycle of read latency.
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            data_i[i] <= cfg_of(i).base + (cfg_of(i).inc ? {3'd0, addr_o[i]} : 8'd0);

    function automatic logic [9:0] got(int id);
        return {tx_o[id], dtx[id], drx[id], busy[id], done[id], addr_o[id]};
    endfunction

    // Expected {tx, dirTX, dirRX, busy, done, addr} after edge n, RQ having risen just before edge 0.
    function automatic logic [9:0] expect_at(int id, int n);
        cfg_t       c;
        int         s, l, e, k, m, b, bp, fs, a;
        logic [7:0] d;
        logic       t;
        c  = cfg_of(id);
        s  = 2 + 3 * c.g;
        l  = c.cpb * (10 + (c.par != 0 ? 1 : 0) + c.stp - 1 + c.gap);
        e  = s + c.nb * l;
        fs = c.par != 0 ? 10 : 9;
        if (n < 2)
            return 10'h200;
        if (n < s) begin
            k = n - 2;
            return {1'b1, k >= 2 * c.g, k >= c.g, 1'b1, 1'b0, 5'd0};
        end
        if (n < e) begin
            m  = n - s;
            b  = m / l;
            bp = (m % l) / c.cpb;
            d  = c.base + (c.inc ? 8'(b) : 8'd0);
            t  = bp == 0 ? 1'b0 :
                 bp <= 8 ? d[bp-1] :
                 (bp == 9 && c.par != 0) ? (c.par == 1 ? ^d : ~^d) : 1'b1;
            a  = bp >= fs ? (b + 1) % c.nb : b;
            return {t, 1'b1, 1'b1, 1'b1, 1'b0, 5'(a)};
        end
        if (n < e + 2 * c.g) begin
            k = n - e;
            return {1'b1, k < c.g, 1'b1, 1'b1, 1'b0, 5'd0};
        end
        return {1'b1, 1'b0, 1'b0, 1'b0, n == e + 2 * c.g, 5'd0};
    endfunction

    task automatic check(input string tag, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b ({tx,dirTX,dirRX,busy,done,addr})", tag, act, exp);
        end
    endtask

    // Raise RQ, then compare every edge; optionally drop RQ and pulse reset at given edges.
    task automatic run(input int id, input int nedges, input int rq_drop, input int rst_at);
        @(negedge clk);
        rq[id] = 1'b1;
        for (int n = 0; n < nedges; n++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("dut%0d edge %0d", id, n), got(id),
                  (rst_at >= 0 && n > rst_at) ? 10'h200 : expect_at(id, n));
            if (n == rq_drop - 1) rq[id] = 1'b0;
            if (n == rst_at) reset = 1'b0;
            if (n == rst_at + 1) reset = 1'b1;
        end
        rq[id] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rq[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("reset dut%0d", i), got(i), 10'h200);
        reset = 1'b1;
        run(0, 285, 200, -1);
        run(0, 102, 98, 100);
        run(0, 285, 200, -1);
        run(1, 185, 20, -1);
        run(2, 110, 20, -1);
        run(3, 60, 1000, -1);
        run(3, 30, 1000, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
